// File: rtl/cpx2real_pkg.sv
// Shared widths, limits and carrier phase encoding for the fs/4 complex-to-real upconverter.
package cpx2real_pkg;
  localparam int IN_W        = 13;
  localparam int OUT_W       = 12;
  localparam int MIX_W       = 14;
  localparam int FIFO_W      = 2 * IN_W;
  localparam int SAT_MAX     = 2047;
  localparam int SAT_MIN     = -2048;
  localparam int CADENCE_DEF = 20;

  typedef enum logic [1:0] {
    PH_0   = 2'd0,
    PH_90  = 2'd1,
    PH_180 = 2'd2,
    PH_270 = 2'd3
  } phase_t;

  // Round half up by one bit, then clamp into the DAC range.
  function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [MIX_W-1:0] v);
    logic signed [MIX_W-1:0] one;
    logic signed [MIX_W-1:0] hi;
    logic signed [MIX_W-1:0] lo;
    logic signed [MIX_W-1:0] h;
    one = MIX_W'(1);
    hi  = MIX_W'(SAT_MAX);
    lo  = MIX_W'(SAT_MIN);
    h   = (v + one) >>> 1;
    if (h > hi)      round_sat = OUT_W'(SAT_MAX);
    else if (h < lo) round_sat = OUT_W'(SAT_MIN);
    else             round_sat = h[OUT_W-1:0];
  endfunction
endpackage

// File: rtl/cpx2real_sample_fifo.sv
// Synchronous FIFO, registered occupancy; no fall-through, writes ignored when full,
// reads ignored when empty. Asynchronous reset empties it immediately.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 26
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cpx2real.sv
// Buffers complex baseband samples and emits one fs/4-mixed, rounded real sample
// every CADENCE cycles; an empty buffer at an output slot yields 0 plus an underrun pulse.
module cpx2real
  import cpx2real_pkg::*;
#(
  parameter int CADENCE    = CADENCE_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    data_rdy,
  input  logic signed [IN_W-1:0]  re,
  input  logic signed [IN_W-1:0]  im,
  output logic                    ready,
  output logic signed [OUT_W-1:0] x_tx,
  output logic                    tx_rdy,
  output logic                    underrun,
  output logic                    overrun
);
  localparam int CW = $clog2(CADENCE);

  logic [CW-1:0]           cnt;
  logic                    tick;
  phase_t                  p;
  logic                    full;
  logic                    empty;
  logic [FIFO_W-1:0]       rdata;
  logic signed [IN_W-1:0]  re_f;
  logic signed [IN_W-1:0]  im_f;
  logic signed [MIX_W-1:0] re_x;
  logic signed [MIX_W-1:0] im_x;
  logic signed [MIX_W-1:0] v;

  assign tick  = (cnt == '0);
  assign ready = !full;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (data_rdy && ready),
    .wdata ({re, im}),
    .rd    (tick && !empty),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign re_f = rdata[FIFO_W-1:IN_W];
  assign im_f = rdata[IN_W-1:0];
  assign re_x = MIX_W'(re_f);
  assign im_x = MIX_W'(im_f);

  // re*cos - im*sin with the carrier stepping a quarter turn per output sample
  always_comb begin
    v = re_x;
    case (p)
      PH_0:    v = re_x;
      PH_90:   v = -im_x;
      PH_180:  v = -re_x;
      default: v = im_x;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= CW'(CADENCE - 1);
      p        <= PH_0;
      x_tx     <= '0;
      tx_rdy   <= 1'b0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      tx_rdy   <= 1'b0;
      underrun <= 1'b0;
      if (data_rdy && full) overrun <= 1'b1;
      if (tick) begin
        cnt    <= CW'(CADENCE - 1);
        p      <= phase_t'(p + 2'd1);
        tx_rdy <= 1'b1;
        if (empty) begin
          x_tx     <= '0;
          underrun <= 1'b1;
        end else begin
          x_tx <= round_sat(v);
        end
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_cpx2real.sv
// Directed and random stimulus for cpx2real against a queue-based sample/slot model.
module tb_cpx2real;
  localparam int CADENCE = 20;
  localparam int DEPTH   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              data_rdy;
  logic signed [12:0] re;
  logic signed [12:0] im;
  logic              ready;
  logic signed [11:0] x_tx;
  logic              tx_rdy;
  logic              underrun;
  logic              overrun;

  cpx2real #(.CADENCE(CADENCE), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_rdy (data_rdy),
    .re       (re),
    .im       (im),
    .ready    (ready),
    .x_tx     (x_tx),
    .tx_rdy   (tx_rdy),
    .underrun (underrun),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: buffered samples, cycles since reset, carrier phase, expected outputs
  int q_re[$];
  int q_im[$];
  int n;
  int mp;
  int mx;
  bit mtx;
  bit mun;
  bit mov;

  int obs[$];
  int un_cnt;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  function automatic int sat(input int x);
    if (x > 2047) return 2047;
    if (x < -2048) return -2048;
    return x;
  endfunction

  task automatic model_clear();
    q_re.delete();
    q_im.delete();
    n = 0; mp = 0; mx = 0; mtx = 0; mun = 0; mov = 0;
    obs.delete();
    un_cnt = 0;
  endtask

  task automatic model_edge(input bit dr, input int r, input int i);
    bit tick;
    bit is_full;
    int a;
    int b;
    int v;
    tick    = ((n % CADENCE) == CADENCE - 1);
    is_full = (q_re.size() == DEPTH);
    if (dr && is_full) mov = 1;
    mtx = 0;
    mun = 0;
    if (tick) begin
      mtx = 1;
      if (q_re.size() > 0) begin
        a = q_re.pop_front();
        b = q_im.pop_front();
        case (mp)
          0: v = a;
          1: v = -b;
          2: v = -a;
          default: v = b;
        endcase
        mx = sat((v + 1) >>> 1);
      end else begin
        mx  = 0;
        mun = 1;
      end
      mp = (mp + 1) % 4;
    end
    if (dr && !is_full) begin
      q_re.push_back(r);
      q_im.push_back(i);
    end
    n++;
  endtask

  task automatic step(input bit dr, input int r, input int i);
    data_rdy = dr;
    re = 13'(r);
    im = 13'(i);
    @(posedge clk);
    model_edge(dr, r, i);
    #1;
    chk("ready", ready, (q_re.size() != DEPTH));
    chk("x_tx", x_tx, mx);
    chk("tx_rdy", tx_rdy, mtx);
    chk("underrun", underrun, mun);
    chk("overrun", overrun, mov);
    if (tx_rdy === 1'b1) obs.push_back(int'(x_tx));
    if (underrun === 1'b1) un_cnt++;
  endtask

  task automatic idle(input int cyc);
    for (int k = 0; k < cyc; k++) step(0, 0, 0);
  endtask

  // asserted away from the clock edge; outputs must clear before any edge
  task automatic do_reset(input int cyc);
    data_rdy = 0;
    reset = 1;
    #1;
    chk("rst_x_tx", x_tx, 0);
    chk("rst_tx_rdy", tx_rdy, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ready", ready, 1);
    repeat (cyc) @(posedge clk);
    #1;
    reset = 0;
    model_clear();
  endtask

  initial begin
    int exp030[4];
    int exp031[8];
    int seq031_re[8];
    int th;
    reset = 1;
    data_rdy = 0;
    re = 0;
    im = 0;
    model_clear();
    #1;
    do_reset(2);

    // idle: three underrun slots
    idle(3 * CADENCE);
    chk("idle_strobes", obs.size(), 3);
    chk("idle_underruns", un_cnt, 3);
    for (int k = 0; k < obs.size(); k++) chk("idle_x0", obs[k], 0);

    // four identical samples across all four carrier phases
    do_reset(2);
    for (int k = 0; k < 4; k++) step(1, 1000, 600);
    idle(4 * CADENCE - 4);
    exp030 = '{500, -300, -500, 300};
    chk("phase_count", obs.size(), 4);
    for (int k = 0; k < 4 && k < obs.size(); k++) chk("phase_seq", obs[k], exp030[k]);

    // rounding and saturation corners
    do_reset(2);
    seq031_re = '{3, 0, -4096, 0, -3, 0, 4095, 0};
    exp031    = '{2, 0, 2047, 0, -1, 0, -2047, 0};
    for (int k = 0; k < 8; k++) begin
      step(1, seq031_re[k], 0);
      idle(CADENCE - 1);
    end
    chk("round_count", obs.size(), 8);
    for (int k = 0; k < 8 && k < obs.size(); k++) chk("round_val", obs[k], exp031[k]);

    // overflow: fifth back-to-back write dropped, overrun sticky
    do_reset(2);
    for (int k = 0; k < 4; k++) step(1, 100 * (k + 1), -7 * k);
    chk("full_ready_low", ready, 0);
    step(1, 1234, 1234);
    chk("overrun_set", overrun, 1);
    idle(4 * CADENCE);
    chk("overrun_sticky", overrun, 1);
    chk("full_strobes", obs.size(), 4);
    chk("full_no_underrun", un_cnt, 0);

    // reset while holding three samples
    for (int k = 0; k < 3; k++) step(1, 555, 333);
    do_reset(2);
    idle(CADENCE);
    chk("rst_mid_strobes", obs.size(), 1);
    chk("rst_mid_underrun", un_cnt, 1);
    step(1, 1000, 600);
    idle(CADENCE - 1);
    chk("rst_mid_strobes2", obs.size(), 2);
    if (obs.size() > 1) chk("rst_mid_phase1", obs[1], -300);

    // write coinciding with a tick on an empty FIFO
    do_reset(2);
    idle(CADENCE - 1);
    step(1, 100, -50);
    idle(CADENCE);
    chk("coin_strobes", obs.size(), 2);
    chk("coin_underrun", un_cnt, 1);
    if (obs.size() > 1) begin
      chk("coin_first", obs[0], 0);
      chk("coin_second", obs[1], 25);
    end

    // random traffic at several write densities, with one reset in the middle
    do_reset(2);
    for (int blk = 0; blk < 6; blk++) begin
      th = (blk % 3 == 0) ? 1 : ((blk % 3 == 1) ? 4 : 16);
      if (blk == 3) do_reset(1 + int'($urandom_range(0, 2)));
      for (int k = 0; k < 500; k++)
        step($urandom_range(0, 15) < th, int'($urandom_range(0, 8191)) - 4096,
             int'($urandom_range(0, 8191)) - 4096);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpx2real.md
CPX2REAL -- requirements
Module: cpx2real

Interface
REQ-001 Parameter CADENCE, default 20: clock cycles between output sample strobes (>= 2).
REQ-002 Parameter FIFO_DEPTH, default 4: input sample buffer depth (power of two).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_rdy  input  1  one-cycle strobe; re/im valid this cycle.
REQ-006 re  input  13  signed in-phase baseband sample.
REQ-007 im  input  13  signed quadrature baseband sample.
REQ-008 ready  output  1  high when the FIFO is not full (a write will be accepted).
REQ-009 x_tx  output  12  signed real passband sample to the transmitter DAC path.
REQ-010 tx_rdy  output  1  one-cycle strobe marking a new x_tx value.
REQ-011 underrun  output  1  one-cycle pulse when an output slot finds the FIFO empty.
REQ-012 overrun  output  1  sticky flag set when data_rdy arrives while full; cleared only by reset.

Function
REQ-013 The FIFO SHALL write {re, im} on a cycle where data_rdy=1 and ready=1.
REQ-014 data_rdy=1 with the FIFO full SHALL drop the sample and set overrun, even if a pop occurs the same cycle.
REQ-015 A write to an empty FIFO SHALL NOT bypass to the output on the same cycle (no fall-through).
REQ-016 A down-counter SHALL reload CADENCE-1 after reset and on reaching 0; cycle with count==0 is the "tick".
REQ-017 On a tick with FIFO non-empty: pop one entry, compute mix, register x_tx, assert tx_rdy for exactly one cycle after the tick edge.
REQ-018 On a tick with FIFO empty: x_tx<=0, tx_rdy<=1, underrun<=1 (one cycle each).
REQ-019 A 2-bit carrier phase p (fs/4 carrier) SHALL increment modulo 4 on every tick, including underrun ticks.
REQ-020 Mix value v (14-bit signed) SHALL be p=0: re; p=1: -im; p=2: -re; p=3: +im (v = re*cos - im*sin).
REQ-021 x_tx SHALL equal (v+1)>>>1 (round half up), saturated to [-2048, 2047].
REQ-022 x_tx SHALL hold its value between ticks; tx_rdy and underrun SHALL be low outside tick-following cycles.
REQ-023 Simultaneous accepted write and pop SHALL leave the occupancy unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-024 ready SHALL be a registered function of occupancy (combinationally independent of data_rdy).

Reset
REQ-025 Reset SHALL clear x_tx=0, tx_rdy=0, underrun=0, overrun=0, p=0, FIFO empty (ready=1), counter=CADENCE-1.
REQ-026 Reset asserted mid-operation SHALL discard all buffered samples immediately; first tick after release occurs CADENCE cycles later with p=0.

Structure
REQ-027 Shared package/include SHALL hold: input width 13, output width 12, mix width 14, saturation limits 2047/-2048, default CADENCE, phase encodings.
REQ-028 One sub-module sample_fifo (synchronous FIFO, 26-bit data, full/empty outputs) SHALL be instantiated; cadence counter, mixer and rounding stay in cpx2real.

Verification
REQ-029 Reset, no input for 3*CADENCE cycles -> three tx_rdy strobes spaced 20 cycles, x_tx=0, underrun pulse with each, overrun=0.
REQ-030 Write (re,im)=(1000,600) four times, pre-filled before first tick -> x_tx sequence 500, -300, -500, 300 (p=0..3).
REQ-031 Write re=-4096 at p=2 -> v=4096 -> x_tx=2047 (saturated); re=4095 at p=2 -> x_tx=-2047; re=3 at p=0 -> x_tx=2; re=-3 at p=0 -> x_tx=-1.
REQ-032 Write 5 samples back-to-back with no tick in between -> ready low after 4th, 5th dropped, overrun stays 1 until reset; outputs follow first four.
REQ-033 Assert reset for 2 cycles while FIFO holds 3 samples -> all outputs cleared at once, ready=1, next tick 20 cycles after release shows underrun and p restarted at 0.
REQ-034 Write on same cycle as a tick with FIFO empty -> that tick underruns (x_tx=0); the written sample appears at the next tick.
